// File: rtl/mem_in_burst_pkg.sv
// rtl/mem_in_burst_pkg.sv - shared constants for the banked input memory
package mem_in_burst_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int MEM8_DEPTH = 256;
  localparam int MEM8_AW    = 8;

  function automatic int addr_w(input int banks);
    return $clog2(banks) + MEM8_AW;
  endfunction

endpackage

// File: rtl/mem_in_burst_if.sv
// rtl/mem_in_burst_if.sv - write, burst control and read stream bundle
interface mem_in_burst_if
  import mem_in_burst_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BANKS  = 16
);
  localparam int AW = addr_w(BANKS);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic [AW-1:0]     start_addr;
  logic [AW:0]       len;
  logic              busy;
  logic              done;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_ready;

  modport master (
    output wr_en, wr_addr, wr_data, start, start_addr, len, rd_ready,
    input  busy, done, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, start_addr, len, rd_ready,
    output busy, done, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/mem8.sv
// rtl/mem8.sv - 256x8 single-port macro model, active-low CEN/WEN, registered Q
module mem8
  import mem_in_burst_pkg::*;
(
  input  logic                clk,
  input  logic                cen,
  input  logic                wen,
  input  logic [MEM8_AW-1:0]  a,
  input  logic [7:0]          d,
  output logic [7:0]          q
);
  logic [7:0] mem_q [MEM8_DEPTH];

  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!wen) mem_q[a] <= d;
      else      q        <= mem_q[a];
    end
  end
endmodule

// File: rtl/mem_in_skid.sv
// rtl/mem_in_skid.sv - 2-entry FIFO holding returned words (data + last flag)
module mem_in_skid #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] ent_q [2];
  logic [W-1:0] ent_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      ent_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      ent_q    <= ent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = ent_q[rd_ptr_q];
endmodule

// File: rtl/mem_in_burst.sv
// rtl/mem_in_burst.sv - banked mem8 grid with single-cycle writes and a credit-paced burst reader
module mem_in_burst
  import mem_in_burst_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BANKS  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_in_burst_if.slave  bus
);
  localparam int LANES = DATA_W / 8;
  localparam int BW    = $clog2(BANKS);
  localparam int AW    = addr_w(BANKS);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   remain_q, remain_d;
  logic          infl_q, infl_d;
  logic [BW-1:0] infl_bank_q, infl_bank_d;
  logic          infl_last_q, infl_last_d;
  logic          done_q, done_d;

  logic          issue;
  logic          pop;
  logic [2:0]    credit_sum;
  logic [1:0]    fifo_count;
  logic          fifo_valid;
  logic [DATA_W:0] fifo_head;
  logic [DATA_W-1:0] rd_word;

  logic [BANKS-1:0]              bank_cen;
  logic                          mem_wen;
  logic [MEM8_AW-1:0]            mem_a;
  logic [BANKS-1:0][DATA_W-1:0]  bank_q;

  assign fifo_valid = (fifo_count != 2'd0);
  assign pop        = fifo_valid & bus.rd_ready;
  // Words already queued plus the one in the SRAM pipe, less the one leaving now
  assign credit_sum = {1'b0, fifo_count} + {2'b0, infl_q} - {2'b0, pop};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            addr_d   = bus.start_addr;
            remain_d = bus.len;
            state_d  = ST_READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (!bus.wr_en && (credit_sum < 3'd2)) begin
          issue    = 1'b1;
          addr_d   = addr_q + AW'(1);
          remain_d = remain_q - (AW+1)'(1);
          if (remain_q == (AW+1)'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && fifo_head[DATA_W]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    infl_d      = issue;
    infl_bank_d = issue ? addr_q[AW-1:MEM8_AW] : infl_bank_q;
    infl_last_d = issue && (remain_q == (AW+1)'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      infl_q      <= 1'b0;
      infl_bank_q <= '0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      infl_q      <= infl_d;
      infl_bank_q <= infl_bank_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  // A write owns the single port; the reader only drives it when it issues
  assign mem_wen = ~bus.wr_en;
  assign mem_a   = bus.wr_en ? bus.wr_addr[MEM8_AW-1:0] : addr_q[MEM8_AW-1:0];

  always_comb begin
    bank_cen = '1;
    for (int b = 0; b < BANKS; b++) begin
      if (bus.wr_en && (bus.wr_addr[AW-1:MEM8_AW] == BW'(b))) bank_cen[b] = 1'b0;
      if (issue && (addr_q[AW-1:MEM8_AW] == BW'(b)))          bank_cen[b] = 1'b0;
    end
  end

  for (genvar gb = 0; gb < BANKS; gb++) begin : g_bank
    logic [DATA_W-1:0] q_bank;
    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
      mem8 u_mem8 (
        .clk (clk),
        .cen (bank_cen[gb]),
        .wen (mem_wen),
        .a   (mem_a),
        .d   (bus.wr_data[8*gl +: 8]),
        .q   (q_bank[8*gl +: 8])
      );
    end
    assign bank_q[gb] = q_bank;
  end

  assign rd_word = bank_q[infl_bank_q];

  mem_in_skid #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (infl_q),
    .push_data ({infl_last_q, rd_word}),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.rd_valid = fifo_valid;
  assign bus.rd_data  = fifo_head[DATA_W-1:0];
  assign bus.rd_last  = fifo_head[DATA_W] & fifo_valid;
endmodule

// File: tb/tb_mem_in_burst.sv
// tb/tb_mem_in_burst.sv - directed bench for mem_in_burst (BANKS=4, DATA_W=16)
module tb_mem_in_burst;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [15:0] exp_mem [1024];

  mem_in_burst_if #(.DATA_W(16), .BANKS(4)) bus ();

  mem_in_burst #(.DATA_W(16), .BANKS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input int addr, input logic [15:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr[9:0];
    bus.wr_data = data;
    exp_mem[addr] = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  // mode 0: ready=1, 1: random ready, 2: writes every 3rd cycle, 3: start pulsed while busy
  task automatic run_burst(input int saddr, input int n, input int mode, input string name);
    int k, idx, done_k, dones, writes, a, waddr;
    logic stalled, rdy, held_l;
    logic [15:0] held_d, wdata;
    bus.start_addr = saddr[9:0];
    bus.len        = n[10:0];
    bus.start      = 1'b1;
    bus.rd_ready   = 1'b1;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_start got %b want 1", name, bus.busy);
    end
    k = 0; idx = 0; done_k = -1; dones = 0; writes = 0; stalled = 1'b0;
    held_d = '0; held_l = 1'b0;
    while (k < n*4 + 60 && (done_k < 0 || k < done_k + 2)) begin
      tick();
      k++;
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        if (done_k < 0) begin
          done_k = k;
          vectors++;
          if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_at_done got busy=%b valid=%b want 0 0", name, bus.busy, bus.rd_valid);
          end
        end
      end
      if (stalled) begin
        vectors++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== held_d || bus.rd_last !== held_l) begin
          miscompares++;
          $display("FAIL %s stall_stable k=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   name, k, bus.rd_valid, bus.rd_data, bus.rd_last, held_d, held_l);
        end
      end
      rdy = (mode == 1) ? 1'($urandom_range(1, 0)) : 1'b1;
      bus.rd_ready = rdy;
      stalled = 1'b0;
      if (bus.rd_valid === 1'b1) begin
        if (rdy) begin
          a = (saddr + idx) % 1024;
          vectors++;
          if (bus.rd_data !== exp_mem[a] || bus.rd_last !== (idx == n - 1)) begin
            miscompares++;
            $display("FAIL %s word%0d addr=%0d got d=%h l=%b want d=%h l=%b",
                     name, idx, a, bus.rd_data, bus.rd_last, exp_mem[a], (idx == n - 1));
          end
          if (mode == 0 || mode == 3) begin
            vectors++;
            if (k !== 2 + idx) begin
              miscompares++;
              $display("FAIL %s word%0d_cycle got %0d want %0d", name, idx, k, 2 + idx);
            end
          end
          idx++;
        end else begin
          stalled = 1'b1;
          held_d  = bus.rd_data;
          held_l  = bus.rd_last;
        end
      end
      if (mode == 2 && k % 3 == 0 && k >= 3 && k <= 15) begin
        waddr = (writes == 0) ? 40 : 500 + writes;
        wdata = (writes == 0) ? 16'hBEEF : 16'h1000 + 16'(writes);
        bus.wr_en   = 1'b1;
        bus.wr_addr = waddr[9:0];
        bus.wr_data = wdata;
        exp_mem[waddr] = wdata;
        writes++;
      end
      if (mode == 3 && k == 3) begin
        bus.start      = 1'b1;
        bus.start_addr = 10'd0;
        bus.len        = 11'd4;
      end
    end
    bus.wr_en    = 1'b0;
    bus.rd_ready = 1'b1;
    vectors++;
    if (idx !== n) begin
      miscompares++;
      $display("FAIL %s word_count got %0d want %0d", name, idx, n);
    end
    vectors++;
    if (dones !== 1) begin
      miscompares++;
      $display("FAIL %s done_pulses got %0d want 1", name, dones);
    end
    if (mode != 1) begin
      vectors++;
      if (done_k !== n + 2 + writes) begin
        miscompares++;
        $display("FAIL %s done_cycle got %0d want %0d", name, done_k, n + 2 + writes);
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_valid !== 1'b0 ||
        bus.rd_last !== 1'b0 || bus.rd_data !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got busy=%b done=%b v=%b l=%b d=%h want all 0",
               bus.busy, bus.done, bus.rd_valid, bus.rd_last, bus.rd_data);
    end
  endtask

  task automatic test_fill_and_basic();
    for (int a = 0; a < 1024; a++) wr_word(a, 16'(a * 3));
    run_burst(0, 1024, 0, "basic");
  endtask

  task automatic test_wrap();
    run_burst(1020, 8, 0, "wrap");
  endtask

  task automatic test_backpressure();
    run_burst(200, 64, 1, "backpressure");
  endtask

  task automatic test_write_contention();
    run_burst(32, 32, 2, "contention");
  endtask

  task automatic test_start_ignored();
    run_burst(100, 8, 3, "start_ignored");
  endtask

  task automatic test_len_zero();
    bus.len   = 11'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_pulse got done=%b busy=%b v=%b want 1 0 0", bus.done, bus.busy, bus.rd_valid);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_after got done=%b busy=%b v=%b want 0 0 0", bus.done, bus.busy, bus.rd_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    bus.start_addr = 10'd0;
    bus.len        = 11'd64;
    bus.rd_ready   = 1'b0;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    vectors++;
    if (bus.rd_valid !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midburst_pre got v=%b busy=%b want 1 1", bus.rd_valid, bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.rd_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold%0d got done=%b busy=%b v=%b want 0 0 0",
                 i, bus.done, bus.busy, bus.rd_valid);
      end
    end
    rst_n        = 1'b1;
    bus.rd_ready = 1'b1;
    tick();
  endtask

  task automatic test_after_reset();
    for (int a = 5; a < 11; a++) wr_word(a, 16'(a) ^ 16'h5A5A);
    run_burst(5, 6, 0, "after_reset");
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.len        = '0;
    bus.rd_ready   = 1'b0;
    repeat (2) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_fill_and_basic();
    test_wrap();
    test_backpressure();
    test_write_contention();
    test_start_ignored();
    test_len_zero();
    test_reset_mid_burst();
    test_after_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
